// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage: load/store over req/ack, branch resolve, writeback beat
// Memory ops stall upstream in ACCESS until ack or a bounded wait expires.
module mem_stage #(
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [WORD_SIZE-1:0] ex_alu_out,
  input  logic                 ex_alu_zero,
  input  logic [WORD_SIZE-1:0] ex_store_data,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic                 ex_reg_write,
  input  logic [4:0]           ex_dest,
  input  logic                 ex_branch,
  input  logic [WORD_SIZE-1:0] ex_branch_target,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [WORD_SIZE-1:0] dmem_addr,
  output logic [WORD_SIZE-1:0] dmem_wdata,
  input  logic [WORD_SIZE-1:0] dmem_rdata,
  input  logic                 dmem_ack,
  output logic                 wb_valid,
  output logic                 wb_reg_write,
  output logic [4:0]           wb_dest,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic                 branch_taken,
  output logic [WORD_SIZE-1:0] branch_target,
  output logic                 align_err,
  output logic                 bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t             r_state, w_next_state;
  logic [CW-1:0]      r_cnt;
  logic               r_we;
  logic               r_reg_write;
  logic [4:0]         r_dest;
  logic [WORD_SIZE-1:0] r_addr, r_wdata;

  logic w_accept, w_is_mem, w_misaligned, w_start, w_in_access, w_timeout;

  assign w_in_access  = (r_state == ACCESS);
  assign ex_ready     = (r_state == IDLE);
  assign w_accept     = ex_valid && ex_ready;
  assign w_is_mem     = ex_mem_read || ex_mem_write;
  assign w_misaligned = (ex_alu_out[1:0] != 2'b00);
  assign w_start      = w_accept && w_is_mem && !w_misaligned;
  // The wait counter reaches TIMEOUT on this edge; ack on the same edge takes priority.
  assign w_timeout    = w_in_access && !dmem_ack && (r_cnt == CW'(TIMEOUT - 1));

  assign dmem_req   = w_in_access;
  assign dmem_we    = w_in_access && r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next_state = ACCESS;
      ACCESS:  if (dmem_ack || w_timeout) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_we          <= 1'b0;
      r_reg_write   <= 1'b0;
      r_dest        <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_dest       <= '0;
      wb_data       <= '0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      align_err     <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      branch_taken <= 1'b0;
      align_err    <= 1'b0;
      bus_err      <= 1'b0;

      if (w_accept) begin
        if (ex_branch && ex_alu_zero) begin
          branch_taken  <= 1'b1;
          branch_target <= ex_branch_target;
        end
        if (!w_is_mem) begin
          wb_valid     <= 1'b1;
          wb_data      <= ex_alu_out;
          wb_dest      <= ex_dest;
          wb_reg_write <= ex_reg_write;
        end else if (w_misaligned) begin
          align_err <= 1'b1;
          wb_valid  <= 1'b1;
          wb_dest   <= ex_dest;
        end else begin
          r_addr      <= ex_alu_out;
          r_wdata     <= ex_store_data;
          r_we        <= ex_mem_write;
          r_reg_write <= ex_reg_write && !ex_mem_write;
          r_dest      <= ex_dest;
          r_cnt       <= '0;
        end
      end

      if (w_in_access) begin
        if (dmem_ack) begin
          wb_valid     <= 1'b1;
          wb_dest      <= r_dest;
          wb_reg_write <= r_reg_write;
          if (!r_we) wb_data <= dmem_rdata;
        end else if (w_timeout) begin
          bus_err  <= 1'b1;
          wb_valid <= 1'b1;
          wb_dest  <= r_dest;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_out;
  logic        ex_alu_zero;
  logic [31:0] ex_store_data;
  logic        ex_mem_read, ex_mem_write, ex_reg_write;
  logic [4:0]  ex_dest;
  logic        ex_branch;
  logic [31:0] ex_branch_target;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        align_err, bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage #(.WORD_SIZE(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_alu_zero(ex_alu_zero),
    .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_dest(ex_dest),
    .ex_branch(ex_branch), .ex_branch_target(ex_branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_dest(wb_dest), .wb_data(wb_data),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .align_err(align_err), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_alu_out = 0; ex_alu_zero = 0; ex_store_data = 0;
    ex_mem_read = 0; ex_mem_write = 0; ex_reg_write = 0; ex_dest = 0;
    ex_branch = 0; ex_branch_target = 0;
  endtask

  logic [31:0] alu_vals [3] = '{32'h5, 32'hA, 32'hF};
  logic [4:0]  dest_vals[3] = '{5'd3, 5'd4, 5'd5};

  initial begin
    clear_ex();
    rst_n = 0; dmem_ack = 0; dmem_rdata = 0;
    step(); step();
    check("rst_wb_valid", 32'(wb_valid), 32'h0);
    check("rst_dmem_req", 32'(dmem_req), 32'h0);
    check("rst_ex_ready", 32'(ex_ready), 32'h1);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_br_target", branch_target, 32'h0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    rst_n = 1;

    // back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      ex_valid = 1; ex_reg_write = 1; ex_alu_out = alu_vals[i]; ex_dest = dest_vals[i];
      check("b2b_ready", 32'(ex_ready), 32'h1);
      step();
      check("b2b_wb_valid", 32'(wb_valid), 32'h1);
      check("b2b_wb_data", wb_data, alu_vals[i]);
      check("b2b_wb_dest", 32'(wb_dest), 32'(dest_vals[i]));
      check("b2b_wb_rw", 32'(wb_reg_write), 32'h1);
    end
    clear_ex();
    step();
    check("b2b_idle_valid", 32'(wb_valid), 32'h0);
    check("b2b_hold_data", wb_data, 32'hF);

    // load with ack on third ACCESS cycle
    ex_valid = 1; ex_mem_read = 1; ex_alu_out = 32'h100; ex_reg_write = 1; ex_dest = 5'd7;
    step();
    clear_ex();
    for (int i = 0; i < 3; i++) begin
      check("ld_req", 32'(dmem_req), 32'h1);
      check("ld_addr", dmem_addr, 32'h100);
      check("ld_we", 32'(dmem_we), 32'h0);
      check("ld_ready", 32'(ex_ready), 32'h0);
      check("ld_no_wb", 32'(wb_valid), 32'h0);
      if (i == 2) begin dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; end
      step();
    end
    dmem_ack = 0; dmem_rdata = 0;
    check("ld_wb_valid", 32'(wb_valid), 32'h1);
    check("ld_wb_data", wb_data, 32'hDEADBEEF);
    check("ld_wb_rw", 32'(wb_reg_write), 32'h1);
    check("ld_wb_dest", 32'(wb_dest), 32'd7);
    check("ld_req_drop", 32'(dmem_req), 32'h0);
    check("ld_ready_back", 32'(ex_ready), 32'h1);
    step();
    check("ld_pulse_end", 32'(wb_valid), 32'h0);

    // store with immediate ack
    ex_valid = 1; ex_mem_write = 1; ex_alu_out = 32'h40; ex_store_data = 32'h1234;
    ex_reg_write = 1; ex_dest = 5'd9;
    step();
    clear_ex();
    check("st_req", 32'(dmem_req), 32'h1);
    check("st_we", 32'(dmem_we), 32'h1);
    check("st_addr", dmem_addr, 32'h40);
    check("st_wdata", dmem_wdata, 32'h1234);
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    check("st_wb_valid", 32'(wb_valid), 32'h1);
    check("st_wb_rw", 32'(wb_reg_write), 32'h0);
    check("st_req_drop", 32'(dmem_req), 32'h0);
    check("st_we_drop", 32'(dmem_we), 32'h0);

    // misaligned load
    ex_valid = 1; ex_mem_read = 1; ex_alu_out = 32'h102; ex_reg_write = 1; ex_dest = 5'd2;
    step();
    clear_ex();
    check("mis_no_req", 32'(dmem_req), 32'h0);
    check("mis_align_err", 32'(align_err), 32'h1);
    check("mis_wb_valid", 32'(wb_valid), 32'h1);
    check("mis_wb_rw", 32'(wb_reg_write), 32'h0);
    check("mis_ready", 32'(ex_ready), 32'h1);
    step();
    check("mis_pulse_end", 32'(align_err), 32'h0);

    // timeout with TIMEOUT=4
    ex_valid = 1; ex_mem_read = 1; ex_alu_out = 32'h200; ex_reg_write = 1; ex_dest = 5'd1;
    step();
    clear_ex();
    for (int i = 0; i < 4; i++) begin
      check("to_req", 32'(dmem_req), 32'h1);
      check("to_no_err", 32'(bus_err), 32'h0);
      step();
    end
    check("to_bus_err", 32'(bus_err), 32'h1);
    check("to_wb_valid", 32'(wb_valid), 32'h1);
    check("to_wb_rw", 32'(wb_reg_write), 32'h0);
    check("to_ready", 32'(ex_ready), 32'h1);
    check("to_req_drop", 32'(dmem_req), 32'h0);
    dmem_ack = 1; dmem_rdata = 32'hBAD;
    step();
    dmem_ack = 0; dmem_rdata = 0;
    check("late_ack_no_wb", 32'(wb_valid), 32'h0);
    check("late_ack_no_err", 32'(bus_err), 32'h0);
    step();
    check("late_ack_no_wb2", 32'(wb_valid), 32'h0);

    // branch taken / not taken
    ex_valid = 1; ex_branch = 1; ex_alu_zero = 1; ex_branch_target = 32'h2000;
    step();
    clear_ex();
    check("br_taken", 32'(branch_taken), 32'h1);
    check("br_target", branch_target, 32'h2000);
    step();
    check("br_pulse_end", 32'(branch_taken), 32'h0);
    ex_valid = 1; ex_branch = 1; ex_alu_zero = 0; ex_branch_target = 32'h3000;
    step();
    clear_ex();
    check("br_not_taken", 32'(branch_taken), 32'h0);

    // reset during ACCESS
    ex_valid = 1; ex_mem_read = 1; ex_alu_out = 32'h300; ex_reg_write = 1; ex_dest = 5'd6;
    step();
    clear_ex();
    check("rstacc_req", 32'(dmem_req), 32'h1);
    rst_n = 0;
    step();
    rst_n = 1;
    check("rstacc_req_drop", 32'(dmem_req), 32'h0);
    check("rstacc_no_wb", 32'(wb_valid), 32'h0);
    check("rstacc_ready", 32'(ex_ready), 32'h1);
    dmem_ack = 1;
    step();
    dmem_ack = 0;
    check("rstacc_no_wb2", 32'(wb_valid), 32'h0);
    check("rstacc_addr_clr", dmem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage that sits directly downstream of the ALU in the MIPS datapath. It accepts one executed instruction per handshake: the ALU result and zero flag, plus control bits. It performs the data-memory load or store over a req/ack bus, resolves BEQ-style branches from the zero flag, and presents a single-cycle writeback beat to the register-file stage. It stalls the execute stage while a memory access is outstanding and bounds every access with a timeout.

## Interface
- WORD_SIZE, 32: datapath width; alu_out, store data and memory data are all this width.
- TIMEOUT, 255: maximum number of cycles spent in ACCESS before bus_err is raised; must be at least 1.

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  stage can accept; combinational, equals (state==IDLE)
- ex_alu_out  in  WORD_SIZE  ALU result, or effective address for memory ops
- ex_alu_zero  in  1  ALU zero flag
- ex_store_data  in  WORD_SIZE  data for stores
- ex_mem_read / ex_mem_write  in  1 each  load / store
- ex_reg_write  in  1  instruction writes a register
- ex_dest  in  5  destination register
- ex_branch  in  1  instruction is a branch-on-equal
- ex_branch_target  in  WORD_SIZE  branch target PC
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr / dmem_wdata  out  WORD_SIZE  address / write data
- dmem_rdata  in  WORD_SIZE  read data, valid with ack
- dmem_ack  in  1  access complete
- wb_valid  out  1  writeback beat, one-cycle pulse
- wb_reg_write  out  1  register write enable for the beat
- wb_dest  out  5  destination register
- wb_data  out  WORD_SIZE  writeback value
- branch_taken  out  1  one-cycle pulse
- branch_target  out  WORD_SIZE  target PC, valid with branch_taken
- align_err / bus_err  out  1 each  one-cycle error pulses

## Operation
- States: IDLE, ACCESS.
- Accept: an instruction is accepted at a rising edge where ex_valid && ex_ready. While ex_ready=0, ex_* inputs are ignored and upstream holds them.
- Non-memory instruction (mem_read=mem_write=0), accepted in IDLE:
  - Next cycle: wb_valid=1, wb_data=ex_alu_out, wb_dest=ex_dest, wb_reg_write=ex_reg_write.
  - State stays IDLE.
- Branch: if ex_branch && ex_alu_zero, branch_taken=1 and branch_target=ex_branch_target for exactly the cycle after acceptance. Otherwise branch_taken=0.
- Memory instruction:
  - If ex_alu_out[1:0]!=0, it is misaligned. No request is issued. The next cycle has align_err=1, wb_valid=1, wb_reg_write=0. State stays IDLE.
  - If aligned, go to ACCESS: dmem_req=1, dmem_addr=ex_alu_out, dmem_wdata=ex_store_data, dmem_we=ex_mem_write. If mem_read and mem_write are both set, the store wins and no register is written.
  - Address, write data and we are registered at acceptance and held stable throughout ACCESS.
- ACCESS:
  - On an edge with dmem_ack=1: go to IDLE and drop dmem_req.
  - Next cycle: wb_valid=1. A load gives wb_data=dmem_rdata and wb_reg_write=ex_reg_write. A store gives wb_reg_write=0.
  - A wait counter clears on entry and increments each ACCESS cycle without ack. On the edge where it reaches TIMEOUT: go to IDLE, drop dmem_req, bus_err=1 and wb_valid=1 with wb_reg_write=0 the next cycle.
  - If ack and timeout occur on the same edge, ack wins.
- dmem_ack sampled in IDLE is ignored.
- Outside a wb_valid beat, wb_data and wb_dest hold their last values.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, counter=0. dmem_req, dmem_we, wb_valid, wb_reg_write, branch_taken, align_err and bus_err are 0. dmem_addr, dmem_wdata, wb_data, wb_dest and branch_target are 0.
- Reset mid-ACCESS abandons the access: dmem_req=0 after that edge and no writeback beat is produced.
- Non-memory latency: 1 cycle from acceptance to wb_valid. Throughput: one instruction per cycle.
- Memory latency: 1 + N cycles, where N is the number of ACCESS cycles up to and including the ack cycle (N≥1). With ack in the first ACCESS cycle, wb_valid occurs 2 cycles after acceptance.
- ex_ready is low for every ACCESS cycle. A new instruction can be accepted at the first edge after returning to IDLE; this edge coincides with the wb_valid beat.
- Pulses (wb_valid, branch_taken, align_err, bus_err) last exactly one cycle.

## Test plan
- Back-to-back ALU ops: accept alu_out=0x5, 0xA, 0xF with reg_write=1, dest=3,4,5 -> wb_valid on three consecutive cycles with matching data and dest; ex_ready stays 1.
- Load with 3-cycle memory: addr=0x100, ack on the third ACCESS cycle with rdata=0xDEADBEEF -> dmem_req high for 3 cycles with addr stable; ex_ready low for 3 cycles; wb_data=0xDEADBEEF, wb_reg_write=1 at cycle 4 after acceptance.
- Store with immediate ack: addr=0x40, store_data=0x1234 -> dmem_we=1, wdata=0x1234 for one cycle; wb_valid=1 with wb_reg_write=0.
- Misaligned load at addr=0x102 -> no dmem_req; align_err=1 and wb_reg_write=0 the next cycle.
- No ack with TIMEOUT=4 -> dmem_req high for 4 cycles, then bus_err=1 and ex_ready=1. An ack arriving later in IDLE causes no beat.
- Branch and reset:
  - ex_branch=1, alu_zero=1, target=0x2000 -> branch_taken pulses with 0x2000.
  - The same with alu_zero=0 -> no pulse.
  - rst_n=0 during ACCESS -> dmem_req=0 next cycle and no wb_valid.
